// File: rtl/cond_resolve_unit_if.sv
// cond_resolve_unit_if: evaluation, condition-code update, result and trap handshake signals
interface cond_resolve_unit_if;
  logic       eval_valid;
  logic       eval_ready;
  logic [6:0] ir31_25;
  logic       is_fb;
  logic [6:0] trap_num;
  logic       icc_we;
  logic [3:0] icc_in;
  logic       fcc_we;
  logic [1:0] fcc_in;
  logic       flush;
  logic       res_valid;
  logic       bcond;
  logic       tcond;
  logic       annul;
  logic       trap_req;
  logic [7:0] trap_tt;
  logic       trap_ack;
  modport master (
    output eval_valid, ir31_25, is_fb, trap_num, icc_we, icc_in, fcc_we, fcc_in, flush, trap_ack,
    input  eval_ready, res_valid, bcond, tcond, annul, trap_req, trap_tt
  );
  modport slave (
    input  eval_valid, ir31_25, is_fb, trap_num, icc_we, icc_in, fcc_we, fcc_in, flush, trap_ack,
    output eval_ready, res_valid, bcond, tcond, annul, trap_req, trap_tt
  );
endinterface

// File: rtl/cond_resolve_unit.sv
// cond_resolve_unit: Bicc/FBfcc/Ticc condition resolution with result pipeline and trap FSM; CRU_FCC_EN enables fcc
module cond_resolve_unit #(
  parameter int         STAGES  = 2,
  parameter logic [7:0] TT_BASE = 8'h80
) (
  input logic            clk,
  input logic            rst_n,
  cond_resolve_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PEND, REQ} state_t;
  state_t state_q, state_d;
  logic [1:0] op;
  logic       a;
  logic [3:0] cond;
  logic [3:0] icc_q, icc_cur;
  logic       n, z, v, c;
  logic [7:0] icc_base;
  logic       icc_ok, fb_b, fb_an, is_br, is_tr, acc;
  logic       br_ok, br_an, new_b, new_t, new_a;
  logic [STAGES-1:0] v_q;
  logic [3:0] d_q [STAGES];
  logic       out_v, out_b, out_t, out_a, out_trap;
  logic [7:0] tt_q;
  assign {op, a, cond} = bus.ir31_25;
  assign icc_cur = bus.icc_we ? bus.icc_in : icc_q;
  assign {n, z, v, c} = icc_cur;
  assign icc_base = {v, n, c, c | z, n ^ v, z | (n ^ v), z, 1'b0};
  assign icc_ok = icc_base[cond[2:0]] ^ cond[3];
  assign is_br = op == 2'b00;
  assign is_tr = op == 2'b10;
  assign acc = bus.eval_valid && bus.eval_ready && !bus.flush;
`ifdef CRU_FCC_EN
  localparam logic [31:0] FTAB = {4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0000};
  logic [1:0] fcc_q, fcc_cur;
  logic [3:0] fmask;
  logic       fcc_ok;
  assign fcc_cur = bus.fcc_we ? bus.fcc_in : fcc_q;
  assign fmask = FTAB[{cond[2:0], 2'b00} +: 4];
  assign fcc_ok = fmask[fcc_cur] ^ cond[3];
  assign fb_b = fcc_ok;
  assign fb_an = a && (!fcc_ok || cond == 4'h8);
  // fcc register: follows every fcc write, untouched by flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fcc_q <= 2'b00;
    else if (bus.fcc_we) fcc_q <= bus.fcc_in;
`else
  logic unused_fcc;
  assign unused_fcc = ^{bus.fcc_we, bus.fcc_in};
  assign fb_b = 1'b0;
  assign fb_an = a;
`endif
  // result of the instruction currently offered, using bypassed condition codes
  always_comb begin
    br_ok = bus.is_fb ? fb_b : icc_ok;
    br_an = bus.is_fb ? fb_an : a && (!icc_ok || cond == 4'h8);
    new_b = is_br && br_ok;
    new_t = is_tr && icc_ok;
    new_a = is_br && br_an;
  end
  // icc register: follows every icc write, untouched by flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) icc_q <= 4'b0000;
    else if (bus.icc_we) icc_q <= bus.icc_in;
  // result pipeline: STAGES deep, flush kills every valid bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= acc;
      d_q[0] <= {new_b, new_t, new_a, is_tr};
      for (int i = 1; i < STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
      if (bus.flush) v_q <= '0;
    end
  assign out_v = v_q[STAGES-1];
  assign {out_b, out_t, out_a, out_trap} = d_q[STAGES-1];
  // trap type captured when the Ticc is accepted, held through the handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tt_q <= 8'h00;
    else if (acc && is_tr) tt_q <= TT_BASE + {1'b0, bus.trap_num};
  // trap FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // trap FSM next state; flush wins over acknowledge and accept
  always_comb begin
    state_d = state_q;
    if (bus.flush) state_d = IDLE;
    else if (state_q == IDLE && acc && is_tr) state_d = PEND;
    else if (state_q == PEND && out_v && out_trap) state_d = out_t ? REQ : IDLE;
    else if (state_q == REQ && bus.trap_ack) state_d = IDLE;
  end
  assign bus.eval_ready = state_q == IDLE;
  assign bus.trap_req = state_q == REQ;
  assign bus.trap_tt = bus.trap_req ? tt_q : 8'h00;
  assign bus.res_valid = out_v;
  assign bus.bcond = out_v && out_b;
  assign bus.tcond = out_v && out_t;
  assign bus.annul = out_v && out_a;
endmodule

// File: tb/tb_cond_resolve_unit.sv
// tb_cond_resolve_unit: directed vectors with a result scoreboard checked by a separate monitor
module tb_cond_resolve_unit;
  localparam int STAGES = 2;
  typedef struct { logic [2:0] r; int due; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0, cyc = 0, n_res = 0, n_before = 0;
  exp_t q[$];
  exp_t e;
  cond_resolve_unit_if bus();
  cond_resolve_unit #(.STAGES(STAGES), .TT_BASE(8'h80)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.res_valid) begin
      n_res++;
      chk("result_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result_bta", {bus.bcond, bus.tcond, bus.annul}, e.r);
        chk("result_latency", cyc, e.due);
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] op, input logic a, input logic [3:0] cond, input logic fb,
                       input logic [6:0] tn, input logic [2:0] r, input bit push);
    chk("issue_ready", bus.eval_ready, 1);
    bus.eval_valid = 1'b1;
    bus.ir31_25 = {op, a, cond};
    bus.is_fb = fb;
    bus.trap_num = tn;
    if (push) q.push_back('{r, cyc + STAGES});
    step();
    bus.eval_valid = 1'b0;
    bus.icc_we = 1'b0;
    bus.fcc_we = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic wait_req();
    for (int i = 0; i < 20 && !bus.trap_req; i++) step();
    chk("trap_req_raised", bus.trap_req, 1);
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("queue_drained", q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.eval_valid = 0; bus.ir31_25 = 0; bus.is_fb = 0; bus.trap_num = 0;
    bus.icc_we = 0; bus.icc_in = 0; bus.fcc_we = 0; bus.fcc_in = 0;
    bus.flush = 0; bus.trap_ack = 0;
    step(); step();
    chk("rst_outputs", {bus.res_valid, bus.bcond, bus.tcond, bus.annul, bus.trap_req}, 0);
    chk("rst_trap_tt", bus.trap_tt, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", bus.eval_ready, 1);
    bus.icc_we = 1; bus.icc_in = 4'b0101;
    step();
    bus.icc_we = 0;
    issue(2'b00, 0, 4'h1, 0, 0, 3'b100, 1);
    issue(2'b00, 1, 4'h8, 0, 0, 3'b101, 1);
    issue(2'b00, 1, 4'h9, 0, 0, 3'b001, 1);
    issue(2'b00, 1, 4'h5, 0, 0, 3'b100, 1);
    issue(2'b00, 1, 4'h0, 0, 0, 3'b001, 1);
    issue(2'b00, 0, 4'hA, 0, 0, 3'b000, 1);
    issue(2'b00, 0, 4'h4, 0, 0, 3'b100, 1);
    issue(2'b00, 1, 4'hB, 0, 0, 3'b100, 1);
    bus.icc_we = 1; bus.icc_in = 4'b1000;
    issue(2'b00, 0, 4'h6, 0, 0, 3'b100, 1);
    issue(2'b00, 0, 4'h1, 0, 0, 3'b000, 1);
    issue(2'b00, 1, 4'h3, 0, 0, 3'b100, 1);
    issue(2'b01, 1, 4'h8, 0, 0, 3'b000, 1);
    issue(2'b11, 1, 4'h8, 0, 0, 3'b000, 1);
`ifdef CRU_FCC_EN
    issue(2'b00, 1, 4'h8, 1, 0, 3'b101, 1);
    bus.fcc_we = 1; bus.fcc_in = 2'd2;
    issue(2'b00, 1, 4'h6, 1, 0, 3'b100, 1);
`else
    issue(2'b00, 1, 4'h8, 1, 0, 3'b001, 1);
    bus.fcc_we = 1; bus.fcc_in = 2'd2;
    issue(2'b00, 1, 4'h6, 1, 0, 3'b001, 1);
`endif
    wait_drain();
    bus.trap_ack = 1;
    step();
    bus.trap_ack = 0;
    chk("ack_idle_ready", bus.eval_ready, 1);
    chk("ack_idle_req", bus.trap_req, 0);
    issue(2'b10, 0, 4'h8, 0, 7'h05, 3'b010, 1);
    chk("pend_not_ready", bus.eval_ready, 0);
    bus.trap_ack = 1;
    step();
    bus.trap_ack = 0;
    wait_req();
    chk("trap_tt", bus.trap_tt, 8'h85);
    step(); step(); step();
    chk("req_held", bus.trap_req, 1);
    chk("req_tt_held", bus.trap_tt, 8'h85);
    chk("req_not_ready", bus.eval_ready, 0);
    bus.trap_ack = 1;
    step();
    bus.trap_ack = 0;
    chk("acked_req", bus.trap_req, 0);
    chk("acked_ready", bus.eval_ready, 1);
    issue(2'b10, 0, 4'h0, 0, 7'h11, 3'b000, 1);
    chk("never_pend", bus.eval_ready, 0);
    step(); step(); step(); step();
    chk("never_ready", bus.eval_ready, 1);
    chk("never_req", bus.trap_req, 0);
    issue(2'b10, 0, 4'hF, 0, 7'h7F, 3'b010, 1);
    wait_req();
    chk("trap_tt_max", bus.trap_tt, 8'hFF);
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("flush_req", bus.trap_req, 0);
    chk("flush_ready", bus.eval_ready, 1);
    wait_drain();
    n_before = n_res;
    issue(2'b00, 0, 4'h8, 0, 0, 3'b000, 0);
    bus.flush = 1;
    step();
    bus.flush = 0;
    bus.flush = 1;
    issue(2'b10, 0, 4'h8, 0, 7'h01, 3'b000, 0);
    chk("flush_blocks_accept", bus.eval_ready, 1);
    for (int i = 0; i < STAGES + 2; i++) step();
    chk("flush_no_results", n_res, n_before);
    issue(2'b10, 0, 4'h8, 0, 7'h02, 3'b000, 0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_pend_outputs", {bus.res_valid, bus.bcond, bus.tcond, bus.annul, bus.trap_req}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_pend_ready", bus.eval_ready, 1);
    issue(2'b00, 0, 4'h6, 0, 0, 3'b000, 1);
    issue(2'b00, 0, 4'hE, 0, 0, 3'b100, 1);
    issue(2'b00, 1, 4'h1, 0, 0, 3'b001, 1);
    wait_drain();
    issue(2'b10, 0, 4'h8, 0, 7'h03, 3'b010, 1);
    wait_req();
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_req_drop", bus.trap_req, 0);
    chk("arst_req_tt", bus.trap_tt, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_req_ready", bus.eval_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
